hilo_muldiv_unit: RTL and testbench

- Parametrised successor to the single-cycle HI/LO holding register.
- Owns the architectural HI/LO pair and contains its own iterative multiplier and restoring divider, so the execute stage no longer precomputes products or quotients.
- Sits beside the ALU in EX. MFHI/MFLO read hi_out/lo_out directly; the hazard unit stalls on busy.

---
 rtl/hilo_muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Architectural HI/LO register pair with a built-in iterative multiplier
//   (shift-add) and restoring divider (shift-subtract). One step per clock,
//   WIDTH steps, then a one-cycle FINISH that applies sign correction and
//   writes HI/LO.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     operation request, sampled only while busy=0
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//             100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
//   src_a     multiplicand / dividend / MTHI-MTLO data
//   src_b     multiplier / divisor
//   cancel    flush; aborts the in-flight op, suppresses a start in IDLE
//   busy      high while an iterative op is in flight
//   done      one-cycle pulse after HI/LO is written by an iterative op
//   div_zero  one-cycle pulse with done for a divide by zero
//   hi_out    current HI
//   lo_out    current LO
//
// Build option:
//   HILO_MADD_EN  when defined, MADD/MADDU accumulate the product into HI:LO;
//                 otherwise op 110/111 are no-ops.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               isDiv;
  logic               negRes;     // product sign, or quotient sign
  logic               negRem;     // remainder takes dividend sign
  logic               divByZero;
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   accHi;      // product high half / partial remainder
  logic [WIDTH-1:0]   accLo;      // multiplier / dividend, shifted out as result bits shift in

`ifdef HILO_MADD_EN
  logic               isMadd;
  logic [2*WIDTH-1:0] maddAcc;
`endif

  // Operand decode and magnitude conversion
  logic             signedOp, divOp, iterOp, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;

  always_comb begin
    signedOp = ~op[0];
    divOp    = (op[2:1] == 2'b01);
`ifdef HILO_MADD_EN
    iterOp   = ~op[2] | (op[2:1] == 2'b11);
`else
    iterOp   = ~op[2];
`endif
    aNeg     = signedOp & src_a[WIDTH-1];
    bNeg     = signedOp & src_b[WIDTH-1];
    aMag     = aNeg ? ('0 - src_a) : src_a;
    bMag     = bNeg ? ('0 - src_b) : src_b;
  end

  // One iteration step
  logic [WIDTH:0]   mulSum, divTrial;
  logic [WIDTH-1:0] nextHi, nextLo;

  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opnd};
    if (isDiv) begin
      // Restoring divide: keep the trial difference only when it is non-negative.
      nextHi = divTrial[WIDTH] ? {accHi[WIDTH-2:0], accLo[WIDTH-1]} : divTrial[WIDTH-1:0];
      nextLo = {accLo[WIDTH-2:0], ~divTrial[WIDTH]};
    end else begin
      nextHi = mulSum[WIDTH:1];
      nextLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  // Sign correction for the final write
  logic [2*WIDTH-1:0] prodRaw, prodFinal;
  logic [WIDTH-1:0]   quotFinal, remFinal;

  always_comb begin
    prodRaw   = {accHi, accLo};
    prodFinal = negRes ? ('0 - prodRaw) : prodRaw;
`ifdef HILO_MADD_EN
    if (isMadd) prodFinal = prodFinal + maddAcc;
`endif
    quotFinal = negRes ? ('0 - accLo) : accLo;
    remFinal  = negRem ? ('0 - accHi) : accHi;
  end

  always_comb busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      isDiv     <= 1'b0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divByZero <= 1'b0;
      opnd      <= '0;
      accHi     <= '0;
      accLo     <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
`ifdef HILO_MADD_EN
      isMadd    <= 1'b0;
      maddAcc   <= '0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (op == OP_MTHI) begin
              hi_out <= src_a;
            end else if (op == OP_MTLO) begin
              lo_out <= src_a;
            end else if (iterOp) begin
              state     <= BUSY;
              cnt       <= '0;
              isDiv     <= divOp;
              negRes    <= aNeg ^ bNeg;
              negRem    <= aNeg;
              divByZero <= divOp && (src_b == '0);
              // Multiply shifts the multiplier out of accLo; divide shifts the dividend out.
              opnd      <= divOp ? bMag : aMag;
              accLo     <= divOp ? aMag : bMag;
              accHi     <= '0;
`ifdef HILO_MADD_EN
              isMadd    <= op[2];
              maddAcc   <= {hi_out, lo_out};
`endif
            end
          end
        end
        BUSY: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            accHi <= nextHi;
            accLo <= nextLo;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (isDiv) begin
              if (divByZero) begin
                div_zero <= 1'b1;
              end else begin
                hi_out <= remFinal;
                lo_out <= quotFinal;
              end
            end else begin
              {hi_out, lo_out} <= prodFinal;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  int nBusy;
  bit gotDone, gotDz;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single-cycle op (MTHI/MTLO) issued in IDLE; optional cancel on the same edge.
  task automatic moveOp(input logic [2:0] o, input logic [31:0] a, input logic c);
    @(negedge clk);
    op = o; src_a = a; src_b = '0; start = 1'b1; cancel = c;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  // Issues an op and counts busy cycles (bounded). cancelAt/intrudeAt are busy-cycle
  // indices at which to raise cancel or a competing MTHI start (0 = never).
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cancelAt, input int intrudeAt,
                       output int nb, output bit dn, output bit dz);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      if (nb == intrudeAt) begin
        start = 1'b1; op = 3'b100; src_a = 32'hAAAA_5555;
      end
      if (nb == cancelAt) cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
    end
    dn = done;
    dz = div_zero;
  endtask

  task automatic checkPulseEnds();
    @(posedge clk); #1;
    check("doneFalls", {62'd0, done, div_zero}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
    #23;
    check("resetHeld", {hi_out, lo_out}, 64'd0);
    check("resetFlags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("resetRel", {hi_out, lo_out}, 64'd0);
    check("resetBusy", {63'd0, busy}, 64'd0);

    moveOp(3'b100, 32'hDEAD_BEEF, 1'b0);
    check("mthi", {hi_out, lo_out}, 64'hDEAD_BEEF_0000_0000);
    check("mthiBusy", {63'd0, busy}, 64'd0);
    moveOp(3'b101, 32'h1234_5678, 1'b0);
    check("mtlo", {hi_out, lo_out}, 64'hDEAD_BEEF_1234_5678);
    check("mtloBusy", {62'd0, busy, done}, 64'd0);
    moveOp(3'b100, 32'h0BAD_F00D, 1'b1);
    check("cancelMthi", {hi_out, lo_out}, 64'hDEAD_BEEF_1234_5678);

    runOp(3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0, nBusy, gotDone, gotDz);
    check("multBusy", 64'(nBusy), 64'd33);
    check("multDone", {62'd0, gotDone, gotDz}, 64'd2);
    check("multRes", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    checkPulseEnds();

    runOp(3'b001, 32'hFFFF_FFFE, 32'd3, 0, 0, nBusy, gotDone, gotDz);
    check("multuBusy", 64'(nBusy), 64'd33);
    check("multuRes", {hi_out, lo_out}, 64'h0000_0002_FFFF_FFFA);

    runOp(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, nBusy, gotDone, gotDz);
    check("divDone", {62'd0, gotDone, gotDz}, 64'd2);
    check("divRes", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    runOp(3'b011, 32'd100, 32'd0, 0, 0, nBusy, gotDone, gotDz);
    check("divzBusy", 64'(nBusy), 64'd33);
    check("divzFlags", {62'd0, gotDone, gotDz}, 64'd3);
    check("divzKeep", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    checkPulseEnds();

    runOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, nBusy, gotDone, gotDz);
    check("divMin", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    runOp(3'b011, 32'd100, 32'd7, 0, 0, nBusy, gotDone, gotDz);
    check("divu", {hi_out, lo_out}, 64'h0000_0002_0000_000E);

    runOp(3'b001, 32'd5, 32'd7, 0, 5, nBusy, gotDone, gotDz);
    check("intrudeBusy", 64'(nBusy), 64'd33);
    check("intrudeRes", {hi_out, lo_out}, 64'd35);

    runOp(3'b001, 32'd9, 32'd9, 10, 0, nBusy, gotDone, gotDz);
    check("cancelBusy", 64'(nBusy), 64'd10);
    check("cancelDone", {63'd0, gotDone}, 64'd0);
    check("cancelKeep", {hi_out, lo_out}, 64'd35);
    checkPulseEnds();

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    op = 3'b001; src_a = 32'd11; src_b = 32'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midReset", {hi_out, lo_out}, 64'd0);
    check("midResetFlags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("afterReset", {62'd0, busy, done}, 64'd0);
    check("afterResetHiLo", {hi_out, lo_out}, 64'd0);

    moveOp(3'b101, 32'd5, 1'b0);
    runOp(3'b111, 32'd3, 32'd4, 0, 0, nBusy, gotDone, gotDz);
`ifdef HILO_MADD_EN
    check("maddBusy", 64'(nBusy), 64'd33);
    check("maddDone", {63'd0, gotDone}, 64'd1);
    check("maddRes", {hi_out, lo_out}, 64'd17);
    runOp(3'b110, 32'hFFFF_FFFF, 32'd20, 0, 0, nBusy, gotDone, gotDz);
    check("maddSigned", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("maddNoBusy", 64'(nBusy), 64'd0);
    check("maddNoDone", {63'd0, gotDone}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("maddNoRes", {hi_out, lo_out}, 64'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
